// File: rtl/spram_arbiter.sv
// Two-client arbiter in front of one 16K x 16 single-port RAM: one access per cycle,
// fixed priority to c0 with c1 aging, or round robin when SPRAM_ARB_RR_EN is defined.
module spram_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c0_req,
  input  logic        c0_we,
  input  logic [13:0] c0_addr,
  input  logic [15:0] c0_wdata,
  input  logic [3:0]  c0_mask,
  output logic        c0_gnt,
  output logic        c0_rvalid,
  input  logic        c1_req,
  input  logic        c1_we,
  input  logic [13:0] c1_addr,
  input  logic [15:0] c1_wdata,
  input  logic [3:0]  c1_mask,
  output logic        c1_gnt,
  output logic        c1_rvalid,
  output logic [15:0] rdata,
  output logic        ram_cs,
  output logic        ram_wen,
  output logic [13:0] ram_addr,
  output logic [15:0] ram_wdata,
  output logic [3:0]  ram_mask,
  input  logic [15:0] ram_rdata
);

  logic c0_rvalid_q, c0_rvalid_d;
  logic c1_rvalid_q, c1_rvalid_d;
  logic win1;

`ifdef SPRAM_ARB_RR_EN
  // last_gnt_q = 1 means c0 took the most recent grant
  logic last_gnt_q, last_gnt_d;
`else
  logic [7:0] wait1_q, wait1_d;
`endif

  always_comb begin
    win1 = c1_req;
    if (c0_req && c1_req) begin
`ifdef SPRAM_ARB_RR_EN
      win1 = last_gnt_q;
`else
      win1 = (wait1_q == 8'(MAX_WAIT));
`endif
    end

    // Grants are suppressed during reset so nothing reaches the RAM or the rvalid pipe
    c1_gnt = !reset && c1_req && win1;
    c0_gnt = !reset && c0_req && !win1;

    ram_cs    = c0_gnt || c1_gnt;
    ram_wen   = c1_gnt ? c1_we : (c0_gnt && c0_we);
    ram_addr  = win1 ? c1_addr  : c0_addr;
    ram_wdata = win1 ? c1_wdata : c0_wdata;
    ram_mask  = win1 ? c1_mask  : c0_mask;

    c0_rvalid_d = c0_gnt && !c0_we;
    c1_rvalid_d = c1_gnt && !c1_we;

`ifdef SPRAM_ARB_RR_EN
    last_gnt_d = last_gnt_q;
    if (c0_gnt)      last_gnt_d = 1'b1;
    else if (c1_gnt) last_gnt_d = 1'b0;
`else
    wait1_d = 8'd0;
    if (c1_req && !c1_gnt)
      wait1_d = (wait1_q >= 8'(MAX_WAIT)) ? 8'(MAX_WAIT) : wait1_q + 8'd1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c0_rvalid_q <= 1'b0;
      c1_rvalid_q <= 1'b0;
`ifdef SPRAM_ARB_RR_EN
      last_gnt_q  <= 1'b0;
`else
      wait1_q     <= 8'd0;
`endif
    end else begin
      c0_rvalid_q <= c0_rvalid_d;
      c1_rvalid_q <= c1_rvalid_d;
`ifdef SPRAM_ARB_RR_EN
      last_gnt_q  <= last_gnt_d;
`else
      wait1_q     <= wait1_d;
`endif
    end
  end

  assign c0_rvalid = c0_rvalid_q;
  assign c1_rvalid = c1_rvalid_q;
  assign rdata     = ram_rdata;

endmodule

// File: tb/tb_spram_arbiter.sv
// Bench for spram_arbiter: behavioural RAM, directed scenarios, then randomized
// traffic checked against a rule-level reference model.
module tb_spram_arbiter;
  localparam int MAXW = 4;

  logic        clk, reset;
  logic        c0_req, c0_we, c0_gnt, c0_rvalid;
  logic [13:0] c0_addr;
  logic [15:0] c0_wdata;
  logic [3:0]  c0_mask;
  logic        c1_req, c1_we, c1_gnt, c1_rvalid;
  logic [13:0] c1_addr;
  logic [15:0] c1_wdata;
  logic [3:0]  c1_mask;
  logic [15:0] rdata, ram_wdata, ram_rdata;
  logic        ram_cs, ram_wen;
  logic [13:0] ram_addr;
  logic [3:0]  ram_mask;

  spram_arbiter #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset),
    .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_mask(c0_mask), .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid),
    .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c1_mask(c1_mask), .c1_gnt(c1_gnt), .c1_rvalid(c1_rvalid),
    .rdata(rdata), .ram_cs(ram_cs), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_mask(ram_mask), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] wd,
                                        input logic [3:0] m);
    logic [15:0] r;
    r = old;
    for (int n = 0; n < 4; n++) if (m[n]) r[4*n +: 4] = wd[4*n +: 4];
    return r;
  endfunction

  // Behavioural single-port RAM driven by the DUT
  logic [15:0] mem [16384];
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_wen) mem[ram_addr] <= merge(mem[ram_addr], ram_wdata, ram_mask);
      else         ram_rdata     <= mem[ram_addr];
    end
  end

  // Reference model state
  logic [15:0] ref_mem [16384];
  int          m_wait;
  bit          m_last_c0;
  bit          m_pend0, m_pend1;
  logic [15:0] m_pdata;
  bit          e_g0, e_g1;
  int          vectors = 0, miscompares = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs at negedge, then advance the model across posedge
  task automatic step();
    bit both, w1;
    @(negedge clk);
    both = c0_req && c1_req;
`ifdef SPRAM_ARB_RR_EN
    w1 = both ? m_last_c0 : c1_req;
`else
    w1 = both ? (m_wait == MAXW) : c1_req;
`endif
    e_g1 = !reset && c1_req && w1;
    e_g0 = !reset && c0_req && !e_g1;
    chk("c0_gnt", 16'(c0_gnt), 16'(e_g0));
    chk("c1_gnt", 16'(c1_gnt), 16'(e_g1));
    chk("ram_cs", 16'(ram_cs), 16'(e_g0 || e_g1));
    if (e_g0 || e_g1 || reset)
      chk("ram_wen", 16'(ram_wen), 16'(e_g1 ? c1_we : (e_g0 && c0_we)));
    if (e_g0 || e_g1) begin
      chk("ram_addr",  16'(ram_addr), 16'(e_g1 ? c1_addr : c0_addr));
      if (e_g1 ? c1_we : c0_we) begin
        chk("ram_wdata", ram_wdata, e_g1 ? c1_wdata : c0_wdata);
        chk("ram_mask",  16'(ram_mask), 16'(e_g1 ? c1_mask : c0_mask));
      end
    end
    chk("c0_rvalid", 16'(c0_rvalid), 16'(m_pend0));
    chk("c1_rvalid", 16'(c1_rvalid), 16'(m_pend1));
    if (m_pend0 || m_pend1) chk("rdata", rdata, m_pdata);
    @(posedge clk);
    if (reset) begin
      m_wait = 0; m_last_c0 = 0; m_pend0 = 0; m_pend1 = 0;
    end else begin
      m_pend0 = e_g0 && !c0_we;
      m_pend1 = e_g1 && !c1_we;
      if (e_g0) begin
        if (c0_we) ref_mem[c0_addr] = merge(ref_mem[c0_addr], c0_wdata, c0_mask);
        else       m_pdata = ref_mem[c0_addr];
      end
      if (e_g1) begin
        if (c1_we) ref_mem[c1_addr] = merge(ref_mem[c1_addr], c1_wdata, c1_mask);
        else       m_pdata = ref_mem[c1_addr];
      end
      m_wait = (c1_req && !e_g1) ? ((m_wait + 1 > MAXW) ? MAXW : m_wait + 1) : 0;
      if (e_g0) m_last_c0 = 1;
      else if (e_g1) m_last_c0 = 0;
    end
    #1;
  endtask

  task automatic set_c0(input bit rq, input bit we, input logic [13:0] a,
                        input logic [15:0] d, input logic [3:0] m);
    c0_req = rq; c0_we = we; c0_addr = a; c0_wdata = d; c0_mask = m;
  endtask

  task automatic set_c1(input bit rq, input bit we, input logic [13:0] a,
                        input logic [15:0] d, input logic [3:0] m);
    c1_req = rq; c1_we = we; c1_addr = a; c1_wdata = d; c1_mask = m;
  endtask

  int g1_count;

  initial begin
    for (int i = 0; i < 16384; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    m_wait = 0; m_last_c0 = 0; m_pend0 = 0; m_pend1 = 0; m_pdata = '0;
    ram_rdata = '0;
    // Reset with a read pending on c0: nothing may be granted or returned
    reset = 1'b1;
    set_c0(1, 0, 14'h0005, 16'h0, 4'h0);
    set_c1(0, 0, 14'h0, 16'h0, 4'h0);
    step(); step();
    chk("rst_rvalid0", 16'(c0_rvalid), 16'd0);
    reset = 1'b0;
    set_c0(0, 0, 14'h0, 16'h0, 4'h0);
    step();

    // c0 full write, then c1 reads it back
    set_c0(1, 1, 14'h0010, 16'hBEEF, 4'b1111);
    step();
    set_c0(0, 0, 14'h0, 16'h0, 4'h0);
    set_c1(1, 0, 14'h0010, 16'h0, 4'h0);
    step();
    chk("t2_c1_rvalid", 16'(c1_rvalid), 16'd1);
    chk("t2_c0_rvalid", 16'(c0_rvalid), 16'd0);
    chk("t2_rdata", rdata, 16'hBEEF);
    set_c1(0, 0, 14'h0, 16'h0, 4'h0);

    // Partial nibble write, then read-back
    set_c0(1, 1, 14'h0010, 16'h1234, 4'b0011);
    step();
    set_c0(1, 0, 14'h0010, 16'h0, 4'h0);
    step();
    chk("t3_rdata", rdata, 16'hBE34);
    set_c0(0, 0, 14'h0, 16'h0, 4'h0);
    step();

    // Steady contention for 15 cycles
    set_c0(1, 0, 14'h0010, 16'h0, 4'h0);
    set_c1(1, 0, 14'h0011, 16'h0, 4'h0);
    g1_count = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (e_g1) g1_count++;
`ifndef SPRAM_ARB_RR_EN
      chk("t4_pattern", 16'(c1_rvalid), 16'((i % 5) == 4));
`endif
    end
`ifndef SPRAM_ARB_RR_EN
    chk("t4_c1_grants", 16'(g1_count), 16'd3);
`endif
    set_c0(0, 0, 14'h0, 16'h0, 4'h0);
    set_c1(0, 0, 14'h0, 16'h0, 4'h0);
    step();

    // Back-to-back c0 reads
    for (int a = 1; a <= 3; a++) begin
      set_c0(1, 0, 14'(a), 16'h0, 4'h0);
      step();
      chk("t6_b2b_rvalid", 16'(c0_rvalid), 16'd1);
    end
    set_c0(0, 0, 14'h0, 16'h0, 4'h0);
    step();

    // Reset lands on the second read grant
    set_c0(1, 0, 14'h0001, 16'h0, 4'h0);
    step();
    set_c0(1, 0, 14'h0002, 16'h0, 4'h0);
    reset = 1'b1;
    step();
    chk("t6_rst_rvalid0", 16'(c0_rvalid), 16'd0);
    chk("t6_rst_rvalid1", 16'(c1_rvalid), 16'd0);
    reset = 1'b0;
    set_c0(0, 0, 14'h0, 16'h0, 4'h0);
    step();

    // Randomized traffic obeying the handshake
    for (int i = 0; i < 600; i++) begin
      if (!c0_req || e_g0)
        set_c0(($urandom_range(3) != 0), 1'($urandom), 14'($urandom_range(15)),
               16'($urandom), 4'($urandom));
      else if ($urandom_range(19) == 0) c0_req = 1'b0;
      if (!c1_req || e_g1)
        set_c1(($urandom_range(3) != 0), 1'($urandom), 14'($urandom_range(15)),
               16'($urandom), 4'($urandom));
      else if ($urandom_range(19) == 0) c1_req = 1'b0;
      reset = ($urandom_range(99) == 0);
      step();
    end
    reset = 1'b0;
    set_c0(0, 0, 14'h0, 16'h0, 4'h0);
    set_c1(0, 0, 14'h0, 16'h0, 4'h0);
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
